// File: rtl/feedback_receiver.sv
// feedback_receiver: deserialises status bytes returned by the kitchen game.
// 8N1 UART receiver (two-flop synchronised input, mid-bit sampling) feeding a
// frame parser that keeps the traveler/machine flags, a staleness timeout,
// and change/framing-error pulses.
// Optional build macro FEEDBACK_PARITY_EN: 8E1 framing with an even-parity
// check; a byte failing parity is discarded and reported via frame_err.
module feedback_receiver #(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       uart_rx,
    output logic       sig_front,
    output logic       sig_hand,
    output logic       sig_processing,
    output logic       sig_machine,
    output logic       feedback_valid,
    output logic       flag_change,
    output logic       frame_err,
    output logic [7:0] last_byte
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned CW  = $clog2(DIV + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] L_DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] L_HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] L_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef FEEDBACK_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_RECOVER
    } state_t;

    logic          r_sync1, r_sync2;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_baud_cnt, w_baud_nxt;
    logic [2:0]    r_bit_cnt, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
`ifdef FEEDBACK_PARITY_EN
    logic          r_parity, w_parity_nxt;
    logic          w_parity_ok;
`endif
    logic          w_rx;
    logic          w_byte_good;
    logic          w_byte_bad;
    logic          w_is_frame;

    logic [3:0]    r_flags;
    logic          r_valid;
    logic          r_flag_change;
    logic          r_frame_err;
    logic [7:0]    r_last_byte;
    logic [TW-1:0] r_to_cnt;

    assign w_rx = r_sync2;
`ifdef FEEDBACK_PARITY_EN
    assign w_parity_ok = ~^{r_shift, r_parity};
`endif
    assign w_is_frame = w_byte_good && (r_shift[7:6] == 2'b00) && (r_shift[1:0] == 2'b01);

    // Two-flop synchroniser for the asynchronous serial line, idling high.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver state, baud/bit counters and shift register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
`ifdef FEEDBACK_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
`ifdef FEEDBACK_PARITY_EN
            r_parity   <= w_parity_nxt;
`endif
        end
    end

    // Next-state logic: half-bit wait to mid start bit, then one sample per bit.
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
`ifdef FEEDBACK_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        w_byte_good  = 1'b0;
        w_byte_bad   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx) begin
                    w_state_nxt = S_START;
                    w_baud_nxt  = L_HALF_M1;
                end
            end
            S_START: begin
                if (r_baud_cnt != '0) begin
                    w_baud_nxt = r_baud_cnt - CW'(1);
                end else if (!w_rx) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = L_DIV_M1;
                    w_bit_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (r_baud_cnt != '0) begin
                    w_baud_nxt = r_baud_cnt - CW'(1);
                end else begin
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    w_baud_nxt  = L_DIV_M1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef FEEDBACK_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
`ifdef FEEDBACK_PARITY_EN
            S_PARITY: begin
                if (r_baud_cnt != '0) begin
                    w_baud_nxt = r_baud_cnt - CW'(1);
                end else begin
                    w_parity_nxt = w_rx;
                    w_baud_nxt   = L_DIV_M1;
                    w_state_nxt  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_baud_cnt != '0) begin
                    w_baud_nxt = r_baud_cnt - CW'(1);
                end else if (w_rx) begin
                    w_state_nxt = S_IDLE;
`ifdef FEEDBACK_PARITY_EN
                    w_byte_good = w_parity_ok;
                    w_byte_bad  = !w_parity_ok;
`else
                    w_byte_good = 1'b1;
`endif
                end else begin
                    w_state_nxt = S_RECOVER;
                    w_byte_bad  = 1'b1;
                end
            end
            S_RECOVER: begin
                if (w_rx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame parser: status flags, staleness timeout and event pulses.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_flags       <= '0;
            r_valid       <= 1'b0;
            r_flag_change <= 1'b0;
            r_frame_err   <= 1'b0;
            r_last_byte   <= '0;
            r_to_cnt      <= '0;
        end else begin
            r_flag_change <= 1'b0;
            r_frame_err   <= w_byte_bad;
            if (w_byte_good) begin
                r_last_byte <= r_shift;
            end
            // An accepted frame takes priority over an expiring timeout.
            if (w_is_frame) begin
                r_flags       <= r_shift[5:2];
                r_valid       <= 1'b1;
                r_to_cnt      <= '0;
                r_flag_change <= (r_shift[5:2] != r_flags);
            end else if (r_valid) begin
                if (r_to_cnt == L_TO_LAST) begin
                    r_valid       <= 1'b0;
                    r_flags       <= '0;
                    r_to_cnt      <= '0;
                    r_flag_change <= |r_flags;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign sig_front      = r_flags[0];
    assign sig_hand       = r_flags[1];
    assign sig_processing = r_flags[2];
    assign sig_machine    = r_flags[3];
    assign feedback_valid = r_valid;
    assign flag_change    = r_flag_change;
    assign frame_err      = r_frame_err;
    assign last_byte      = r_last_byte;

endmodule

// File: tb/tb_feedback_receiver.sv
// tb_feedback_receiver: directed serial stimulus for feedback_receiver with
// hand-computed expected flags, bytes and pulse counts (DIV=16, timeout 2000).
module tb_feedback_receiver;

    localparam int unsigned BIT_CYC = 16;

    logic       clk;
    logic       res;
    logic       uart_rx;
    logic       sig_front, sig_hand, sig_processing, sig_machine;
    logic       feedback_valid, flag_change, frame_err;
    logic [7:0] last_byte;

    int n_checks = 0;
    int n_errors = 0;
    int fc_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int fc_base;
    int fe_base;
`ifdef FEEDBACK_PARITY_EN
    logic par_flip = 1'b0;
`endif

    feedback_receiver #(
        .CLK_FREQ      (1600),
        .BAUD          (100),
        .TIMEOUT_CYCLES(2000)
    ) dut (
        .clk           (clk),
        .res           (res),
        .uart_rx       (uart_rx),
        .sig_front     (sig_front),
        .sig_hand      (sig_hand),
        .sig_processing(sig_processing),
        .sig_machine   (sig_machine),
        .feedback_valid(feedback_valid),
        .flag_change   (flag_change),
        .frame_err     (frame_err),
        .last_byte     (last_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count output pulses on the inactive edge.
    always @(negedge clk) begin
        if (flag_change) fc_cnt++;
        if (frame_err) fe_cnt++;
        if (flag_change && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {sig_machine, sig_processing, sig_hand, sig_front};
    endfunction

    // Drive one frame, holding each bit for BIT_CYC cycles; returns at a negedge
    // at the end of the stop bit, leaving the line at the stop-bit level.
    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (BIT_CYC) @(negedge clk);
        end
`ifdef FEEDBACK_PARITY_EN
        uart_rx = (^data) ^ par_flip;
        repeat (BIT_CYC) @(negedge clk);
`endif
        uart_rx = stop_bit;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    initial begin
        res     = 1'b1;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_flags", 32'(flags()), 32'h0);
        check("rst_valid", 32'(feedback_valid), 32'h0);
        check("rst_last", 32'(last_byte), 32'h0);
        check("rst_pulses", 32'({flag_change, frame_err}), 32'h0);
        res = 1'b0;
        repeat (10) @(negedge clk);

        // 0x3D: all four flags set
        fc_base = fc_cnt;
        send_byte(8'h3D, 1'b1);
        check("3d_flags", 32'(flags()), 32'hF);
        check("3d_valid", 32'(feedback_valid), 32'h1);
        check("3d_last", 32'(last_byte), 32'h3D);
        check("3d_fc", 32'(fc_cnt - fc_base), 32'h1);

        // 0x05 twice, back to back
        fc_base = fc_cnt;
        send_byte(8'h05, 1'b1);
        check("05a_flags", 32'(flags()), 32'h1);
        check("05a_fc", 32'(fc_cnt - fc_base), 32'h1);
        fc_base = fc_cnt;
        send_byte(8'h05, 1'b1);
        check("05b_fc", 32'(fc_cnt - fc_base), 32'h0);
        check("05b_last", 32'(last_byte), 32'h05);
        check("05b_flags", 32'(flags()), 32'h1);

        // 0x42: not a feedback frame; flags and timeout untouched
        fc_base = fc_cnt;
        send_byte(8'h42, 1'b1);
        check("42_last", 32'(last_byte), 32'h42);
        check("42_flags", 32'(flags()), 32'h1);
        check("42_fc", 32'(fc_cnt - fc_base), 32'h0);

        // ~1865 cycles since the last frame: still valid
        repeat (1700) @(negedge clk);
        check("to_pre_valid", 32'(feedback_valid), 32'h1);
        check("to_pre_flags", 32'(flags()), 32'h1);
        // ~2065 cycles: stale (0x42 did not restart the timeout)
        fc_base = fc_cnt;
        repeat (200) @(negedge clk);
        check("to_valid", 32'(feedback_valid), 32'h0);
        check("to_flags", 32'(flags()), 32'h0);
        check("to_fc", 32'(fc_cnt - fc_base), 32'h1);

        // Bad stop bit on 0x05, then the line held low for 40 cycles
        fc_base = fc_cnt;
        fe_base = fe_cnt;
        send_byte(8'h05, 1'b0);
        repeat (40) @(negedge clk);
        check("fe_pulse", 32'(fe_cnt - fe_base), 32'h1);
        check("fe_last", 32'(last_byte), 32'h42);
        check("fe_flags", 32'(flags()), 32'h0);
        check("fe_fc", 32'(fc_cnt - fc_base), 32'h0);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        fe_base = fe_cnt;
        send_byte(8'h09, 1'b1);
        check("09_flags", 32'(flags()), 32'h2);
        check("09_last", 32'(last_byte), 32'h09);
        check("09_valid", 32'(feedback_valid), 32'h1);
        check("09_fe", 32'(fe_cnt - fe_base), 32'h0);

`ifdef FEEDBACK_PARITY_EN
        // Wrong parity: byte discarded with a frame error
        fe_base  = fe_cnt;
        par_flip = 1'b1;
        send_byte(8'h05, 1'b1);
        par_flip = 1'b0;
        check("par_fe", 32'(fe_cnt - fe_base), 32'h1);
        check("par_last", 32'(last_byte), 32'h09);
        check("par_flags", 32'(flags()), 32'h2);
        send_byte(8'h05, 1'b1);
        check("par_ok_flags", 32'(flags()), 32'h1);
        check("par_ok_last", 32'(last_byte), 32'h05);
`endif

        // Short low glitch, shorter than half a bit: rejected silently
        fe_base = fe_cnt;
        uart_rx = 1'b0;
        repeat (6) @(negedge clk);
        uart_rx = 1'b1;
        repeat (200) @(negedge clk);
`ifdef FEEDBACK_PARITY_EN
        check("gl_last", 32'(last_byte), 32'h05);
`else
        check("gl_last", 32'(last_byte), 32'h09);
`endif
        check("gl_fe", 32'(fe_cnt - fe_base), 32'h0);

        // Reset in the middle of a byte
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        res     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_flags", 32'(flags()), 32'h0);
        check("mid_rst_last", 32'(last_byte), 32'h0);
        check("mid_rst_valid", 32'(feedback_valid), 32'h0);
        res = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h3D, 1'b1);
        check("post_rst_flags", 32'(flags()), 32'hF);
        check("post_rst_last", 32'(last_byte), 32'h3D);

        check("fc_fe_overlap", 32'(both_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
